// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response bus; master is the fetch unit.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {pc, instr}; head is read combinationally.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];
  assign do_pop = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Flush drops everything, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage front end: owns the fetch PC, issues credit-limited imem
// requests, queues in-order responses and flushes on redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master imem,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     stall,
  output logic                     valid_out,
  output logic [XLEN-1:0]          instruction_out,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          trace_pc
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] credits_used;
  logic             empty;
  logic             full;
  logic             fire;
  logic             push;
  logic             pop;
  logic             dropping;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign pop          = valid_out & ~stall & ~redirect_valid;
  assign credits_used = SUM_W'(outstanding) + SUM_W'(count) - SUM_W'(pop);

  assign imem.req_valid = ~rst & ~redirect_valid & (credits_used < SUM_W'(QUEUE_DEPTH));
  assign imem.req_addr  = fetch_pc;
  assign fire           = imem.req_valid & imem.req_ready;

  assign dropping   = (drop_count != '0);
  assign push       = imem.resp_valid & ~dropping & ~redirect_valid;
  assign push_entry = '{pc: resp_pc, instr: imem.resp_data};

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign valid_out       = ~empty;
  assign instruction_out = empty ? NOP_INSTR : head.instr;
  assign pc_out          = empty ? '0 : head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      trace_pc    <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc  <= resp_pc + 32'd4;
      end
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem.resp_valid);
      // Outstanding already includes earlier doomed responses, so everything
      // still in flight after this cycle belongs to the abandoned path.
      if (redirect_valid) begin
        drop_count <= outstanding - CNT_W'(imem.resp_valid);
      end else if (imem.resp_valid && dropping) begin
        drop_count <= drop_count - CNT_W'(1);
      end
      if (pop) trace_pc <= pc_out;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full));
  assert property (@(posedge clk) disable iff (rst) !(imem.resp_valid && outstanding == '0));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a variable-latency imem model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] trace_pc;

  instruction_fetch_unit_if imem();

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (imem),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .valid_out       (valid_out),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .trace_pc        (trace_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  logic [31:0] last_pc;
  bit          chk_trace = 1'b0;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pcs still pending after timeout, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory: in-order, data = address, response lat cycles after the request.
  initial begin
    imem.resp_valid = 1'b0;
    imem.resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) mq.delete();
      else if (imem.req_valid && imem.req_ready)
        mq.push_back('{addr: imem.req_addr, due: cyc + lat});
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem.resp_valid = 1'b1;
        imem.resp_data  = mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem.resp_valid = 1'b0;
        imem.resp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: every pop must match the next expected pc; trace_pc follows a cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_trace = 1'b0;
      end else begin
        if (chk_trace) check("trace_pc", trace_pc, last_pc);
        chk_trace = 1'b0;
        if (valid_out && !stall && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %h, required no valid instruction", pc_out);
          end else begin
            exp_pc = exp_q.pop_front();
            check("pc_out", pc_out, exp_pc);
            check("instruction_out", instruction_out, exp_pc);
          end
          last_pc   = pc_out;
          chk_trace = 1'b1;
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    stall            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    imem.req_ready   = 1'b1;
    lat              = 1;
    repeat (3) step();

    @(negedge clk);
    check_bit("rst_valid_out", valid_out, 1'b0);
    check("rst_instruction_out", instruction_out, NOP_INSTR);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_trace_pc", trace_pc, 32'h0);
    check_bit("rst_req_valid", imem.req_valid, 1'b0);
    check("rst_req_addr", imem.req_addr, 32'h0);

    // Zero-wait stream, then hold stall for 3 cycles with pc 0x8 at head.
    step();
    rst = 1'b0;
    push_exp(32'h0, 16);
    @(negedge clk);
    check_bit("valid_cycle0", valid_out, 1'b0);
    step();
    @(negedge clk);
    check_bit("valid_cycle1", valid_out, 1'b0);
    step();
    @(negedge clk);
    check_bit("valid_cycle2", valid_out, 1'b1);
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc_held", pc_out, 32'h8);
      check_bit("stall_valid_held", valid_out, 1'b1);
      check_bit("stall_req_valid", imem.req_valid, 1'b0);
      step();
    end
    stall = 1'b0;
    drain("stream_k1");

    // Reset mid-stream.
    rst            = 1'b1;
    imem.req_ready = 1'b0;
    stall          = 1'b1;
    lat            = 3;
    step();
    @(negedge clk);
    check_bit("midrst_valid_out", valid_out, 1'b0);
    check("midrst_instruction_out", instruction_out, NOP_INSTR);
    check("midrst_pc_out", pc_out, 32'h0);
    check("midrst_req_addr", imem.req_addr, 32'h0);
    check_bit("midrst_req_valid", imem.req_valid, 1'b0);

    // Memory not ready for 4 cycles: address must hold at RESET_PC.
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("notready_req_valid", imem.req_valid, 1'b1);
      check("notready_req_addr", imem.req_addr, 32'h0);
      check_bit("notready_valid_out", valid_out, 1'b0);
      step();
    end

    // k=3: requests for 0x0 and 0x4 in flight, then redirect to 0x100.
    imem.req_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    push_exp(32'h100, 8);
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    lat            = 1;
    @(negedge clk);
    check_bit("redirect_k3_valid_out", valid_out, 1'b0);
    drain("after_redirect_k3");

    // Redirect in a cycle that also has a response and a would-be pop.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check_bit("pre_redirect_valid_out", valid_out, 1'b1);
    check_bit("pre_redirect_resp_valid", imem.resp_valid, 1'b1);
    push_exp(32'h200, 8);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_bit("post_redirect_valid_out", valid_out, 1'b0);
    check_bit("post_redirect_req_valid", imem.req_valid, 1'b1);
    check("post_redirect_req_addr", imem.req_addr, 32'h200);
    drain("after_redirect_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
